mem_access_arbiter: RTL
=======================

// Module: mem_access_arbiter
// PURPOSE
// - Parametrised memory-access controller that shares the single MMU port among NUM_PORTS requesters.
// - Port 0 is instruction fetch; port 1 is the MEM-stage load/store. Further ports are for future masters (L1 refill, debug).
// - Each request is latched, then held stable on the MMU until mmu_mem_ready.
// - The result is returned with a one-cycle ack. A per-port stall output lets pipeline stages freeze while waiting.
// PARAMETERS
// - NUM_PORTS      2    number of requesters, 2..8
// - ADDR_W         32   address width
// - DATA_W         32   data width
// - RR_MODE        0    0: fixed priority, highest index wins (MEM beats IF); 1: round-robin
// - TIMEOUT_CYCLES 255  ACCESS cycles without mmu_mem_ready before an error ack; 0 disables the timeout
// PORTS
// - clk              in   1                  clock
// - reset_n          in   1                  asynchronous, active-low reset
// - req              in   NUM_PORTS          per-port request; held with its fields until ack
// - req_we           in   NUM_PORTS          1 = write, 0 = read
// - req_signed       in   NUM_PORTS          sign-extend narrow reads
// - req_width        in   2*NUM_PORTS        MMU width code, port i at [2i+1:2i]
// - req_addr         in   ADDR_W*NUM_PORTS   address, port i at [ADDR_W*i +: ADDR_W]
// - req_wdata        in   DATA_W*NUM_PORTS   write data, same packing as req_addr
// - ack              out  NUM_PORTS          one-cycle completion pulse, one-hot or zero
// - ack_err          out  1                  valid while an ack bit is 1; 1 = access timed out
// - rdata            out  DATA_W             read data; valid while an ack bit is 1, holds until the next completion
// - stall            out  NUM_PORTS          combinational req[i] & ~ack[i]
// - mmu_read_enable  out  1                  MMU read strobe
// - mmu_write_enable out  1                  MMU write strobe
// - mmu_mem_signed_read out 1                latched req_signed
// - mmu_mem_data_width out 2                 latched req_width
// - mmu_address      out  ADDR_W             latched req_addr
// - mmu_data_in      out  DATA_W             latched req_wdata
// - mmu_data_out     in   DATA_W             MMU read data
// - mmu_mem_ready    in   1                  MMU completion; sampled only in ACCESS
// BEHAVIOUR
// - Reset values: state = IDLE; ack, ack_err, rdata, both enables, address, data_in and signed = 0; width = word; rr_ptr = NUM_PORTS-1.
// - Asynchronous reset mid-access drops the transaction, with no ack. The MMU strobes fall immediately.
// - FSM states: IDLE, ACCESS, DONE.
// - IDLE: if any req bit is 1, choose grant g, latch g and all of port g's fields, and go to ACCESS. Otherwise stay.
// - Fixed priority (RR_MODE=0): g = highest set index.
// - Round-robin (RR_MODE=1): search starts at rr_ptr+1 and wraps modulo NUM_PORTS. rr_ptr <= g on grant.
// - ACCESS: mmu_read_enable = ~we_latched and mmu_write_enable = we_latched. All MMU outputs stay constant for the whole state.
// - ACCESS, mmu_mem_ready = 1: rdata <= mmu_data_out (reads only; writes leave rdata unchanged), ack[g] <= 1, ack_err <= 0, go to DONE.
// - ACCESS timeout: wait counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entry and increments each ACCESS cycle.
//   When it reaches TIMEOUT_CYCLES with ready still 0: ack[g] <= 1, ack_err <= 1, rdata unchanged, go to DONE.
//   Ready in the same cycle as the timeout takes priority and completes normally.
// - DONE: ack/ack_err are high for exactly this cycle, enables are 0, no arbitration, next state IDLE.
//   A requester that still holds req in IDLE is treated as issuing a new request.
// - Latency: req rises in cycle 0 -> ACCESS in cycle 1. If ready arrives in cycle 1, ack is seen in cycle 2. Minimum 3 cycles per access.
// - Field changes on a port while it is granted are ignored, because fields were latched at grant.
// - Dropping req before ack does not abort the access; ack still pulses.
// - Requests arriving during ACCESS/DONE wait; their stall stays 1.
// - Width/sign rules: the block never extends or masks data. Width/sign are forwarded to the MMU unchanged.
// TESTING
// - T1 reset: hold reset_n=0 with req=2'b11 -> ack=0, enables=0, stall=2'b11; after release, port 1 is granted first.
// - T2 single read: port 0 reads addr 0x100, ready in the first ACCESS cycle, mmu_data_out=0xDEADBEEF
//   -> mmu_address=0x100 in cycle 1, ack=2'b01 in cycle 2, rdata=0xDEADBEEF, ack_err=0.
// - T3 fixed priority: req=2'b11 continuously, ready after 2 ACCESS cycles -> grants 1,1,1... and port 0 starves.
// - T4 round-robin: RR_MODE=1, NUM_PORTS=4, req=4'b1111 -> grant order 0,1,2,3,0; no port granted twice in a row.
// - T5 write+wait: port 1 writes 0x12345678 to 0x2000 (width byte), ready after 5 cycles
//   -> mmu_write_enable=1 and address/data stable for all 5 cycles; ack=2'b10 once; rdata unchanged.
// - T6 timeout and abort: TIMEOUT_CYCLES=4, ready never asserted -> ack with ack_err=1 after 4 ACCESS cycles.
//   Repeat with reset_n pulsed in ACCESS -> state IDLE, no ack emitted.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Shares one MMU port among NUM_PORTS requesters (fixed priority or round-robin).
// Latency: grant one cycle after req, ack one cycle after mmu_mem_ready (min 3 cycles/access).
// Backpressure: stall[i] stays high until port i's ack; MMU outputs held until ready or timeout.
module mem_access_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int RR_MODE        = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS-1:0]        req_signed,
  input  logic [2*NUM_PORTS-1:0]      req_width,
  input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
  input  logic [DATA_W*NUM_PORTS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic                        ack_err,
  output logic [DATA_W-1:0]           rdata,
  output logic [NUM_PORTS-1:0]        stall,
  output logic                        mmu_read_enable,
  output logic                        mmu_write_enable,
  output logic                        mmu_mem_signed_read,
  output logic [1:0]                  mmu_mem_data_width,
  output logic [ADDR_W-1:0]           mmu_address,
  output logic [DATA_W-1:0]           mmu_data_in,
  input  logic [DATA_W-1:0]           mmu_data_out,
  input  logic                        mmu_mem_ready
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value seen in the last ACCESS cycle before a timeout fires.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] grant_q;
  logic [PTR_W-1:0] rr_ptr;
  logic             we_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);

  // Pick the winning requester: highest index, or first set bit after rr_ptr.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    if (RR_MODE == 0) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (req[PTR_W'(i)]) grant = PTR_W'(i);
      end
    end else begin
      // Walk the search order backwards so the earliest candidate is assigned last.
      for (int k = NUM_PORTS; k >= 1; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (req[PTR_W'(idx)]) grant = PTR_W'(idx);
      end
    end
  end

  // State register; async reset drops any in-flight access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: grant on any request, leave ACCESS on ready or timeout, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ACCESS;
      ACCESS:  if (mmu_mem_ready || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted request, track wait time, and produce the one-cycle ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack                 <= '0;
      ack_err             <= 1'b0;
      rdata               <= '0;
      we_q                <= 1'b0;
      grant_q             <= '0;
      rr_ptr              <= PTR_W'(NUM_PORTS - 1);
      wait_cnt            <= '0;
      mmu_address         <= '0;
      mmu_data_in         <= '0;
      mmu_mem_signed_read <= 1'b0;
      mmu_mem_data_width  <= WIDTH_WORD;
    end else begin
      ack     <= '0;
      ack_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_q             <= grant;
            we_q                <= req_we[grant];
            mmu_mem_signed_read <= req_signed[grant];
            mmu_mem_data_width  <= req_width[2*int'(grant) +: 2];
            mmu_address         <= req_addr[ADDR_W*int'(grant) +: ADDR_W];
            mmu_data_in         <= req_wdata[DATA_W*int'(grant) +: DATA_W];
            wait_cnt            <= '0;
            if (RR_MODE != 0) rr_ptr <= grant;
          end
        end
        ACCESS: begin
          // Ready wins over a timeout landing in the same cycle.
          if (mmu_mem_ready) begin
            if (!we_q) rdata <= mmu_data_out;
            ack[grant_q] <= 1'b1;
          end else if (timeout_hit) begin
            ack[grant_q] <= 1'b1;
            ack_err      <= 1'b1;
          end else if (TIMEOUT_CYCLES != 0) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // MMU strobes follow the state directly so a reset drops them at once.
  always_comb begin
    mmu_read_enable  = (state == ACCESS) && !we_q;
    mmu_write_enable = (state == ACCESS) && we_q;
    stall            = req & ~ack;
  end

endmodule
